// File: rtl/mem_stage_if.sv
// Data-cache request/response channel between the MEM stage (master) and the cache (slave).
interface mem_stage_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues data-cache requests, aligns load data, hands results to WB.
// Optional macro MEM_LOAD_FWD_EN forwards completed load data to ID from the DONE state.
//
// state | meaning
// IDLE  | no instruction resident
// REQ   | memory request presented, waiting for data_addr_ok
// WAIT  | request accepted by cache, waiting for data_data_ok
// DONE  | result ready, offered to WB
// DRAIN | flushed after request acceptance, swallowing the orphan data_data_ok
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_in,
  input  logic [31:0] ex_pc,
  input  logic [4:0]  ex_op_ld,
  input  logic [2:0]  ex_op_st,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_st_data,
  input  logic        ex_rf_we,
  input  logic [4:0]  ex_rf_waddr,
  input  logic        ex_except,
  input  logic        flush,
  output logic        mem_allowin,
  mem_stage_if.master dbus,
  input  logic        wb_allowin,
  output logic        wb_valid,
  output logic [31:0] wb_pc,
  output logic        wb_rf_we,
  output logic [4:0]  wb_rf_waddr,
  output logic [31:0] wb_rf_wdata,
  output logic        front_valid,
  output logic [4:0]  front_addr,
  output logic [31:0] front_data,
  output logic        mem_is_load
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic        valid_q;
  logic [31:0] pc_q, result_q, st_data_q, rdata_q;
  logic [4:0]  ld_q, waddr_q;
  logic [2:0]  st_q;
  logic        rf_we_q, except_q;

  logic        accept, ex_mem_op, is_ld;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign is_ld       = (|ld_q) & ~except_q;
  assign ex_mem_op   = ((|ex_op_ld) | (|ex_op_st)) & ~ex_except;
  assign mem_allowin = ((state_q == S_IDLE) & ~valid_q) | ((state_q == S_DONE) & wb_allowin);
  assign accept      = ex_valid_in & mem_allowin & ~flush;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = ex_mem_op ? S_REQ : S_DONE;
      S_REQ: begin
        if (flush)                  state_d = dbus.data_addr_ok ? S_DRAIN : S_IDLE;
        else if (dbus.data_addr_ok) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (flush)                  state_d = dbus.data_data_ok ? S_IDLE : S_DRAIN;
        else if (dbus.data_data_ok) state_d = S_DONE;
      end
      S_DONE: begin
        if (flush)           state_d = S_IDLE;
        else if (accept)     state_d = ex_mem_op ? S_REQ : S_DONE;
        else if (wb_allowin) state_d = S_IDLE;
      end
      S_DRAIN: if (dbus.data_data_ok) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      valid_q   <= 1'b0;
      pc_q      <= '0;
      ld_q      <= '0;
      st_q      <= '0;
      result_q  <= '0;
      st_data_q <= '0;
      rf_we_q   <= 1'b0;
      waddr_q   <= '0;
      except_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d == S_REQ) | (state_d == S_WAIT) | (state_d == S_DONE);
      if (accept) begin
        pc_q      <= ex_pc;
        ld_q      <= ex_op_ld;
        st_q      <= ex_op_st;
        result_q  <= ex_result;
        st_data_q <= ex_st_data;
        rf_we_q   <= ex_rf_we;
        waddr_q   <= ex_rf_waddr;
        except_q  <= ex_except;
      end
      if ((state_q == S_WAIT) && dbus.data_data_ok) rdata_q <= ld_ext;
    end
  end

  // Load lane selection and extension; bit order is {ld_b, ld_bu, ld_h, ld_hu, ld_w}.
  always_comb begin
    case (result_q[1:0])
      2'd0:    ld_byte = dbus.data_rdata[7:0];
      2'd1:    ld_byte = dbus.data_rdata[15:8];
      2'd2:    ld_byte = dbus.data_rdata[23:16];
      default: ld_byte = dbus.data_rdata[31:24];
    endcase
    ld_half = result_q[1] ? dbus.data_rdata[31:16] : dbus.data_rdata[15:0];
    ld_ext  = dbus.data_rdata;
    if (ld_q[4])      ld_ext = {{24{ld_byte[7]}}, ld_byte};
    else if (ld_q[3]) ld_ext = {24'd0, ld_byte};
    else if (ld_q[2]) ld_ext = {{16{ld_half[15]}}, ld_half};
    else if (ld_q[1]) ld_ext = {16'd0, ld_half};
  end

  // Store lanes; bit order is {st_b, st_h, st_w}.
  always_comb begin
    dbus.data_wstrb = 4'b0000;
    dbus.data_wdata = 32'd0;
    if (st_q[2]) begin
      dbus.data_wstrb = 4'b0001 << result_q[1:0];
      dbus.data_wdata = {4{st_data_q[7:0]}};
    end else if (st_q[1]) begin
      dbus.data_wstrb = result_q[1] ? 4'b1100 : 4'b0011;
      dbus.data_wdata = {2{st_data_q[15:0]}};
    end else if (st_q[0]) begin
      dbus.data_wstrb = 4'b1111;
      dbus.data_wdata = st_data_q;
    end
  end

  always_comb begin
    dbus.data_size = 2'd0;
    if (ld_q[2] | ld_q[1] | st_q[1]) dbus.data_size = 2'd1;
    else if (ld_q[0] | st_q[0])      dbus.data_size = 2'd2;
  end

  assign dbus.data_req  = (state_q == S_REQ) & ~flush;
  assign dbus.data_wr   = (|st_q) & ~except_q;
  assign dbus.data_addr = result_q;

  assign wb_valid    = valid_q & (state_q == S_DONE);
  assign wb_pc       = pc_q;
  assign wb_rf_we    = rf_we_q;
  assign wb_rf_waddr = waddr_q;
  assign wb_rf_wdata = is_ld ? rdata_q : result_q;

  assign mem_is_load = valid_q & is_ld & (state_q != S_DONE);
  assign front_addr  = waddr_q;
  assign front_data  = wb_rf_wdata;
`ifdef MEM_LOAD_FWD_EN
  assign front_valid = valid_q & rf_we_q & (~is_ld | (state_q == S_DONE));
`else
  assign front_valid = valid_q & rf_we_q & ~is_ld;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected WB handoffs, a monitor pops and compares.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_in;
  logic [31:0] ex_pc, ex_result, ex_st_data;
  logic [4:0]  ex_op_ld, ex_rf_waddr;
  logic [2:0]  ex_op_st;
  logic        ex_rf_we, ex_except, flush, wb_allowin;
  logic        mem_allowin, wb_valid, wb_rf_we, front_valid, mem_is_load;
  logic [31:0] wb_pc, wb_rf_wdata, front_data;
  logic [4:0]  wb_rf_waddr, front_addr;

`ifdef MEM_LOAD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_t;

  wb_t exp_q[$];
  int  n_vec  = 0;
  int  n_fail = 0;

  mem_stage_if dif();

  mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid_in(ex_valid_in), .ex_pc(ex_pc), .ex_op_ld(ex_op_ld), .ex_op_st(ex_op_st),
    .ex_result(ex_result), .ex_st_data(ex_st_data), .ex_rf_we(ex_rf_we),
    .ex_rf_waddr(ex_rf_waddr), .ex_except(ex_except), .flush(flush),
    .mem_allowin(mem_allowin), .dbus(dif), .wb_allowin(wb_allowin),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr),
    .wb_rf_wdata(wb_rf_wdata), .front_valid(front_valid), .front_addr(front_addr),
    .front_data(front_data), .mem_is_load(mem_is_load)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every WB handshake must match the oldest expected entry.
  always @(negedge clk) begin
    wb_t e;
    if (!rst && wb_valid && wb_allowin) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL wb_unexpected: got pc %h, expected no handoff", wb_pc);
      end else begin
        e = exp_q.pop_front();
        chk("wb_handoff", {wb_pc, wb_rf_we, wb_rf_waddr, wb_rf_wdata}, e);
      end
    end
  end

  task automatic set_ex(input logic [31:0] pc, input logic [4:0] ld, input logic [2:0] st,
                        input logic [31:0] addr, input logic [31:0] sd, input logic we,
                        input logic [4:0] wa, input logic exc);
    ex_pc = pc; ex_op_ld = ld; ex_op_st = st; ex_result = addr; ex_st_data = sd;
    ex_rf_we = we; ex_rf_waddr = wa; ex_except = exc; ex_valid_in = 1'b1;
  endtask

  task automatic drive_alu(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] wa);
    set_ex(pc, 5'd0, 3'd0, res, 32'd0, 1'b1, wa, 1'b0);
    exp_q.push_back({pc, 1'b1, wa, res});
  endtask

  task automatic do_mem(input logic [31:0] pc, input logic [4:0] ld, input logic [2:0] st,
                        input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdata,
                        input logic we, input logic [4:0] wa, input int addr_wait,
                        input logic [1:0] e_size, input logic [3:0] e_strb,
                        input logic [31:0] e_wdata, input logic [31:0] e_wb);
    set_ex(pc, ld, st, addr, sd, we, wa, 1'b0);
    exp_q.push_back({pc, we, wa, e_wb});
    #1 chk("mem_accept_allowin", mem_allowin, 1'b1);
    tick();
    ex_valid_in = 1'b0;
    for (int i = 0; i <= addr_wait; i++) begin
      dif.data_addr_ok = (i == addr_wait);
      #1;
      chk("req_fields", {dif.data_req, dif.data_wr, dif.data_size, dif.data_wstrb,
                         dif.data_addr, dif.data_wdata},
          {1'b1, |st, e_size, e_strb, addr, e_wdata});
      chk("req_stall", {mem_allowin, mem_is_load}, {1'b0, |ld});
      tick();
    end
    dif.data_addr_ok = 1'b0;
    dif.data_data_ok = 1'b1;
    dif.data_rdata   = rdata;
    #1 chk("wait_no_req", {dif.data_req, wb_valid}, 2'b00);
    tick();
    dif.data_data_ok = 1'b0;
    dif.data_rdata   = 32'hDEAD_0000;
    #1;
    chk("done_wb_valid", {wb_valid, mem_is_load}, 2'b10);
    chk("done_front", front_valid, we & ((ld == 5'd0) | FWD));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; ex_valid_in = 1'b0; flush = 1'b0; wb_allowin = 1'b1;
    set_ex(32'd0, 5'd0, 3'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    ex_valid_in = 1'b0;
    dif.data_addr_ok = 1'b0; dif.data_data_ok = 1'b0; dif.data_rdata = 32'd0;
    repeat (2) tick();
    chk("reset_outputs", {wb_valid, dif.data_req, front_valid, mem_is_load, wb_rf_wdata,
                          wb_pc, dif.data_wstrb, dif.data_addr}, 96'd0);
    chk("reset_allowin", mem_allowin, 1'b1);
    rst = 1'b0;

    // Non-memory instructions back to back
    drive_alu(32'h100, 32'h1234, 5'd5);
    #1 chk("alu_allowin", mem_allowin, 1'b1);
    tick();
    chk("alu_latency", wb_valid, 1'b1);
    chk("alu_front", {front_valid, front_addr, front_data}, {1'b1, 5'd5, 32'h1234});
    drive_alu(32'h104, 32'h5678, 5'd6);
    #1 chk("alu_b2b_allowin", mem_allowin, 1'b1);
    tick();
    chk("alu_b2b_valid", wb_valid, 1'b1);
    drive_alu(32'h108, 32'h9ABC, 5'd7);
    tick();
    ex_valid_in = 1'b0;
    chk("alu_b2b_valid2", wb_valid, 1'b1);
    tick();
    chk("alu_idle", {wb_valid, mem_allowin}, 2'b01);

    // Loads: ld_b, ld_bu, ld_h, ld_hu, ld_b lane 1, ld_w with addr_ok held low 3 cycles
    do_mem(32'h200, 5'b10000, 3'b000, 32'h1003, 32'hAAAA5555, 32'h80FF_0000, 1'b1, 5'd7, 0,
           2'd0, 4'h0, 32'd0, 32'hFFFF_FF80);
    do_mem(32'h204, 5'b01000, 3'b000, 32'h1003, 32'd0, 32'h80FF_0000, 1'b1, 5'd8, 0,
           2'd0, 4'h0, 32'd0, 32'h0000_0080);
    do_mem(32'h208, 5'b00100, 3'b000, 32'h1002, 32'd0, 32'h80FF_0000, 1'b1, 5'd9, 0,
           2'd1, 4'h0, 32'd0, 32'hFFFF_80FF);
    do_mem(32'h20C, 5'b00010, 3'b000, 32'h1000, 32'd0, 32'h1234_8765, 1'b1, 5'd10, 0,
           2'd1, 4'h0, 32'd0, 32'h0000_8765);
    do_mem(32'h210, 5'b10000, 3'b000, 32'h1001, 32'd0, 32'h0000_7F00, 1'b1, 5'd11, 0,
           2'd0, 4'h0, 32'd0, 32'h0000_007F);
    do_mem(32'h214, 5'b00001, 3'b000, 32'h1004, 32'd0, 32'hDEAD_BEEF, 1'b1, 5'd12, 3,
           2'd2, 4'h0, 32'd0, 32'hDEAD_BEEF);

    // Stores
    do_mem(32'h300, 5'b00000, 3'b010, 32'h2002, 32'h0000_BEEF, 32'd0, 1'b0, 5'd0, 0,
           2'd1, 4'b1100, 32'hBEEF_BEEF, 32'h2002);
    do_mem(32'h304, 5'b00000, 3'b100, 32'h2001, 32'h1234_5678, 32'd0, 1'b0, 5'd0, 0,
           2'd0, 4'b0010, 32'h7878_7878, 32'h2001);
    do_mem(32'h308, 5'b00000, 3'b001, 32'h2000, 32'hCAFE_F00D, 32'd0, 1'b0, 5'd0, 1,
           2'd2, 4'b1111, 32'hCAFE_F00D, 32'h2000);
    do_mem(32'h30C, 5'b00000, 3'b010, 32'h2000, 32'h1111_2222, 32'd0, 1'b0, 5'd0, 0,
           2'd1, 4'b0011, 32'h2222_2222, 32'h2000);

    // Excepting load: no memory access, straight to DONE
    set_ex(32'h600, 5'b00001, 3'b000, 32'h6000, 32'd0, 1'b1, 5'd9, 1'b1);
    exp_q.push_back({32'h600, 1'b1, 5'd9, 32'h6000});
    tick();
    ex_valid_in = 1'b0; ex_except = 1'b0;
    chk("except_no_req", {dif.data_req, wb_valid}, 2'b01);
    tick();

    // Flush in WAIT, data_ok two cycles later: DRAIN, then IDLE
    set_ex(32'h500, 5'b00001, 3'b000, 32'h4000, 32'd0, 1'b1, 5'd4, 1'b0);
    tick();
    ex_valid_in = 1'b0;
    dif.data_addr_ok = 1'b1;
    tick();
    dif.data_addr_ok = 1'b0;
    flush = 1'b1;
    #1 chk("flush_wait_req", dif.data_req, 1'b0);
    tick();
    flush = 1'b0;
    #1 chk("drain_1", {wb_valid, mem_allowin, dif.data_req, mem_is_load}, 4'b0000);
    tick();
    dif.data_data_ok = 1'b1; dif.data_rdata = 32'hBAD0_BAD0;
    #1 chk("drain_2", {wb_valid, mem_allowin, dif.data_req, mem_is_load}, 4'b0000);
    tick();
    dif.data_data_ok = 1'b0;
    #1 chk("drain_exit", {mem_allowin, wb_valid}, 2'b10);

    // Flush in REQ without addr_ok
    set_ex(32'h510, 5'b00001, 3'b000, 32'h4100, 32'd0, 1'b1, 5'd4, 1'b0);
    tick();
    ex_valid_in = 1'b0;
    flush = 1'b1;
    #1 chk("flush_req_noreq", dif.data_req, 1'b0);
    tick();
    flush = 1'b0;
    #1 chk("flush_req_idle", {mem_allowin, wb_valid, dif.data_req}, 3'b100);

    // Flush concurrent with ex_valid_in blocks acceptance
    set_ex(32'h520, 5'd0, 3'd0, 32'h77, 32'd0, 1'b1, 5'd2, 1'b0);
    flush = 1'b1;
    tick();
    ex_valid_in = 1'b0; flush = 1'b0;
    #1 chk("flush_blocks_accept", {wb_valid, mem_allowin}, 2'b01);

    // Flush in DONE while WB stalls
    wb_allowin = 1'b0;
    set_ex(32'h700, 5'd0, 3'd0, 32'h88, 32'd0, 1'b1, 5'd3, 1'b0);
    tick();
    ex_valid_in = 1'b0;
    #1 chk("done_hold", {wb_valid, mem_allowin}, 2'b10);
    flush = 1'b1;
    tick();
    flush = 1'b0; wb_allowin = 1'b1;
    #1 chk("flush_done_idle", {wb_valid, mem_allowin}, 2'b01);

    // Reset in the middle of a transaction
    set_ex(32'h900, 5'b00001, 3'b000, 32'h5000, 32'd0, 1'b1, 5'd1, 1'b0);
    tick();
    ex_valid_in = 1'b0;
    dif.data_addr_ok = 1'b1;
    tick();
    dif.data_addr_ok = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 chk("rst_mid", {mem_allowin, dif.data_req, wb_valid, mem_is_load}, 4'b1000);

    drive_alu(32'hA00, 32'hFACE, 5'd3);
    tick();
    ex_valid_in = 1'b0;
    chk("post_rst_alu", wb_valid, 1'b1);
    repeat (2) tick();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
